fpadd_arbiter: RTL and testbench

Two-requester round-robin scheduler that shares one pipelined single-precision adder (`fpadd_single`) between two operand sources. It accepts operand pairs through valid/ready handshakes and drives the adder's operand inputs. It tracks each issued operation through a tag pipeline matched to the adder latency, then returns each sum with the requester ID. It sits between the operand producers and the adder.

---
 rtl/fpadd_arbiter.sv | 68 ++++++
 tb/tb_fpadd_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_arbiter.sv
// Two-requester round-robin front end for a shared pipelined FP adder.
// Registers the granted operands and tracks each issue through a tag pipe aligned to the adder latency.
module fpadd_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_out,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_id,
  output logic        busy
);

  logic         prio;
  logic         grant;
  logic         gid;
  logic [LAT:0] vld_pipe;
  logic [LAT:0] id_pipe;

  // prio only matters when both requesters are valid; a lone requester always wins
  always_comb begin
    req0_ready = !reset && req0_valid && (!req1_valid || !prio);
    req1_ready = !reset && req1_valid && (!req0_valid ||  prio);
  end

  assign grant = req0_ready | req1_ready;
  assign gid   = req1_ready;
  assign busy  = |vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio     <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_id   <= 1'b0;
    end else begin
      if (grant) begin
        prio  <= !gid;
        add_a <= gid ? req1_a : req0_a;
        add_b <= gid ? req1_b : req0_b;
      end
      // stage LAT lines up with add_out holding that operation's sum
      vld_pipe  <= {vld_pipe[LAT-1:0], grant};
      id_pipe   <= {id_pipe[LAT-1:0], gid};
      res_valid <= vld_pipe[LAT];
      if (vld_pipe[LAT]) begin
        res_data <= add_out;
        res_id   <= id_pipe[LAT];
      end
    end
  end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Bench for fpadd_arbiter: behavioural adder plus an issue-queue model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic with resets.
module tb_fpadd_arbiter;
  localparam int LAT = 2;

  logic        clk = 0;
  logic        reset;
  logic        v0, v1;
  logic [31:0] a0, b0, a1, b1;
  logic        req0_ready, req1_ready;
  logic [31:0] add_a, add_b, add_out, res_data;
  logic        res_valid, res_id, busy;

  always #5 clk = ~clk;

  fpadd_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(req1_ready),
    .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  // simple float adder: decode to real, add, truncate back; specials handled explicitly
  function automatic real f2r(logic [31:0] x);
    real m;
    int  e;
    e = int'(x[30:23]);
    m = real'(x[22:0]) / 8388608.0;
    if (e == 0) m = m * 2.0 ** (-126);
    else        m = (1.0 + m) * 2.0 ** (e - 127);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    int ex;
    d  = $realtobits(r);
    ex = int'(d[62:52]) - 1023 + 127;
    if (d[62:52] == 11'd0 || ex <= 0) return {d[63], 31'b0};
    if (ex >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], ex[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'h7FC00000;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC00000;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    return r2f(f2r(a) + f2r(b));
  endfunction

  logic [31:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= fadd(add_a, add_b);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_out = apipe[LAT-1];

  // model: queue of in-flight ops, each due LAT+1 edges after its accept edge
  typedef struct { int done; logic id; logic [31:0] sum; } op_t;
  typedef struct { int cyc; logic [31:0] d; logic id; } obs_t;
  typedef struct { int cyc; logic id; } gnt_t;
  op_t  q[$];
  obs_t obs[$];
  gnt_t grants[$];

  int          cyc = 0, total = 0, bad = 0, busy_cnt = 0;
  logic        m_prio, m_res_valid, m_res_id, lg0, lg1;
  logic [31:0] m_add_a, m_add_b, m_res_data;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_prio = 0; m_res_valid = 0; m_res_id = 0;
    m_add_a = 0; m_add_b = 0; m_res_data = 0;
  endfunction

  task automatic step();
    logic e0, e1;
    #1;
    if (reset) begin
      model_reset();
      chk("rst_add_a", add_a, 0);
      chk("rst_res_valid", {31'b0, res_valid}, 0);
    end
    e0 = !reset && v0 && (!v1 || !m_prio);
    e1 = !reset && v1 && (!v0 ||  m_prio);
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
    chk("add_a", add_a, m_add_a);
    chk("add_b", add_b, m_add_b);
    chk("res_valid", {31'b0, res_valid}, {31'b0, m_res_valid});
    chk("res_data", res_data, m_res_data);
    chk("res_id", {31'b0, res_id}, {31'b0, m_res_id});
    chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
    if (res_valid) obs.push_back('{cyc, res_data, res_id});
    if (req0_ready || req1_ready) grants.push_back('{cyc + 1, req1_ready});
    if (busy) busy_cnt++;
    lg0 = e0; lg1 = e1;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      m_res_valid = 0;
      if (q.size() != 0 && q[0].done == cyc) begin
        m_res_valid = 1;
        m_res_data  = q[0].sum;
        m_res_id    = q[0].id;
        void'(q.pop_front());
      end
      if (e0 || e1) begin
        m_add_a = e1 ? a1 : a0;
        m_add_b = e1 ? b1 : b0;
        q.push_back('{cyc + LAT + 1, e1, fadd(m_add_a, m_add_b)});
        m_prio = !e1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0; reset = 1;
    step();
    reset = 0;
    obs.delete(); grants.delete(); busy_cnt = 0;
  endtask

  initial begin
    int t0, n0, n1, guard;
    reset = 1; v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single op: 1.0 + 2.0
    v0 = 1; a0 = 32'h3F800000; b0 = 32'h40000000; t0 = cyc + 1;
    step(); v0 = 0;
    repeat (5) step();
    chk("single_nres", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("single_data", obs[0].d, 32'h40400000);
      chk("single_id", {31'b0, obs[0].id}, 0);
      chk("single_lat", obs[0].cyc, t0 + 3);
    end
    chk("single_busy", busy_cnt, 3);

    // contention: both valid for 4 ops each
    do_reset();
    v0 = 1; v1 = 1; a0 = 32'h3F800000; b0 = 32'h3F800000; a1 = 32'h40400000; b1 = 32'h40400000;
    n0 = 0; n1 = 0; guard = 0;
    while ((n0 < 4 || n1 < 4) && guard < 20) begin
      step(); guard++;
      if (lg0 && ++n0 == 4) v0 = 0;
      if (lg1 && ++n1 == 4) v1 = 0;
    end
    repeat (5) step();
    chk("cont_ngrant", grants.size(), 8);
    chk("cont_nres", obs.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++) begin
      chk("cont_gid", {31'b0, grants[i].id}, i % 2);
      chk("cont_gcyc", grants[i].cyc, grants[0].cyc + i);
    end
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      chk("cont_data", obs[i].d, (i % 2) ? 32'h40C00000 : 32'h40000000);
      chk("cont_rid", {31'b0, obs[i].id}, i % 2);
      chk("cont_rcyc", obs[i].cyc, obs[0].cyc + i);
    end

    // lone requester 1 while prio points at 0
    do_reset();
    v1 = 1; a1 = 32'h3F800000; b1 = 32'h3F800000; n1 = 0; guard = 0;
    while (n1 < 3 && guard < 10) begin
      step(); guard++;
      if (lg1) n1++;
    end
    v1 = 0;
    repeat (5) step();
    chk("lone_ngrant", grants.size(), 3);
    chk("lone_nres", obs.size(), 3);
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      chk("lone_id", {31'b0, obs[i].id}, 1);
      chk("lone_rcyc", obs[i].cyc, obs[0].cyc + i);
    end

    // bubbles: issue at local cycles 0, 2, 3
    do_reset();
    t0 = cyc + 1;
    v0 = 1; a0 = 32'h3F800000; b0 = 32'h3F800000; step();
    v0 = 0; step();
    v0 = 1; a0 = 32'h40000000; b0 = 32'h40000000; step();
    a0 = 32'h40400000; b0 = 32'h3F800000; step();
    v0 = 0;
    repeat (6) step();
    chk("bub_nres", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("bub_c0", obs[0].cyc, t0 + 3);
      chk("bub_c1", obs[1].cyc, t0 + 5);
      chk("bub_c2", obs[2].cyc, t0 + 6);
      chk("bub_d2", obs[2].d, 32'h40800000);
    end

    // reset with two ops in flight
    do_reset();
    v0 = 1; a0 = 32'h3F800000; b0 = 32'h3F800000; step();
    v0 = 0; v1 = 1; a1 = 32'h40000000; b1 = 32'h40000000; step();
    v1 = 0; reset = 1; step(); reset = 0;
    repeat (6) step();
    chk("rstmid_nres", obs.size(), 0);
    grants.delete();
    v0 = 1; v1 = 1; step();
    chk("rstmid_first", grants.size() >= 1 ? {31'b0, grants[0].id} : 32'hFFFFFFFF, 0);
    if (lg0) v0 = 0;
    if (lg1) v1 = 0;
    step(); v0 = 0; v1 = 0;
    repeat (5) step();

    // special values: +Inf + -Inf
    do_reset();
    v0 = 1; a0 = 32'h7F800000; b0 = 32'hFF800000; step();
    v0 = 0;
    repeat (4) step();
    chk("nan_nres", obs.size(), 1);
    if (obs.size() >= 1) chk("nan_data", obs[0].d, 32'h7FC00000);

    // randomized traffic with occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!v0 && $urandom_range(9) < 6) begin
        v0 = 1;
        a0 = {1'($urandom), 8'(100 + $urandom_range(50)), 23'($urandom)};
        b0 = ($urandom_range(19) == 0) ? 32'h7F800000 : {1'($urandom), 8'(100 + $urandom_range(50)), 23'($urandom)};
      end
      if (!v1 && $urandom_range(9) < 6) begin
        v1 = 1;
        a1 = {1'($urandom), 8'(100 + $urandom_range(50)), 23'($urandom)};
        b1 = ($urandom_range(19) == 0) ? 32'hFF800000 : {1'($urandom), 8'(100 + $urandom_range(50)), 23'($urandom)};
      end
      reset = ($urandom_range(399) == 0);
      step();
      reset = 0;
      if (lg0) v0 = 0;
      if (lg1) v1 = 0;
    end
    v0 = 0; v1 = 0;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
